// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a length-prefixed little-endian
// byte stream into 32-bit words, writes them from address 0, then releases the core.
module imem_loader #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned IMEM_SZ_IN_KB = 1,
  localparam int unsigned ADDR_WIDTH   = $clog2(IMEM_SZ_IN_KB * 1024)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_wr_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  core_rst_n,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int unsigned DEPTH  = IMEM_SZ_IN_KB * 256;
  localparam int unsigned WCNT_W = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    FIN,
    DONE,
    ERR
  } state_e;

  state_e                state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [23:0]           asm_q, asm_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [WCNT_W-1:0]     word_cnt_q, word_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  accept;
  logic [15:0]           hdr_len;

  // Ready is a pure state decode so the link never sees a valid->ready loop
  assign rx_ready = arst_n && ((state_q == HDR_LO) || (state_q == HDR_HI) || (state_q == DATA));
  assign accept   = rx_valid && rx_ready;
  assign hdr_len  = {rx_data, len_q[7:0]};

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    asm_d      = asm_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      HDR_LO: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = HDR_HI;
        end
      end
      HDR_HI: begin
        if (accept) begin
          len_d[15:8] = rx_data;
          if (hdr_len == 16'd0)             state_d = DONE;
          else if (32'(hdr_len) > DEPTH)    state_d = ERR;
          else                              state_d = DATA;
        end
      end
      DATA: begin
        if (accept) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: asm_d[7:0]   = rx_data;
            2'd1: asm_d[15:8]  = rx_data;
            2'd2: asm_d[23:16] = rx_data;
            default: begin
              // Last lane goes straight to the write register, no extra cycle
              wr_en_d    = 1'b1;
              addr_d     = ADDR_WIDTH'({word_cnt_q, 2'b00});
              wdata_d    = DATA_WIDTH'({rx_data, asm_q});
              word_cnt_d = word_cnt_q + WCNT_W'(1);
              if (16'(word_cnt_q) == (len_q - 16'd1)) state_d = FIN;
            end
          endcase
        end
      end
      FIN:     state_d = DONE;
      default: state_d = state_q;
    endcase
    done_d = (state_d == DONE);
    err_d  = (state_d == ERR);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= HDR_LO;
      len_q      <= '0;
      asm_q      <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      asm_q      <= asm_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      wr_en_q    <= wr_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign imem_wr_en = wr_en_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign load_done  = done_q;
  assign core_rst_n = done_q;
  assign load_err   = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (1 KB image, DEPTH = 256 words).
module tb_imem_loader;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       imem_wr_en;
  logic [9:0] imem_addr;
  logic [31:0] imem_wdata;
  logic       core_rst_n;
  logic       load_done;
  logic       load_err;

  int n_checks = 0;
  int n_fail   = 0;
  int ncyc     = 0;
  int last_acc = 0;
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  logic [7:0]  prog[$] = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                           8'h93, 8'h05, 8'h20, 8'h00};

  imem_loader #(.DATA_WIDTH(32), .IMEM_SZ_IN_KB(1)) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_wr_en (imem_wr_en),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  // Write monitor: each one-cycle strobe is seen at exactly one falling edge
  always @(negedge clk) begin
    ncyc = ncyc + 1;
    if (imem_wr_en === 1'b1) begin
      wr_addr.push_back(int'(imem_addr));
      wr_data.push_back(imem_wdata);
      wr_cyc.push_back(ncyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wgen(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b ^ 8'hA5, ~b, b + 8'h5A, b};
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
    check({tag, "_wr_en"},      32'(imem_wr_en), 32'd0);
    check({tag, "_addr"},       32'(imem_addr),  32'd0);
    check({tag, "_wdata"},      imem_wdata,      32'd0);
    check({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    check({tag, "_load_done"},  32'(load_done),  32'd0);
    check({tag, "_load_err"},   32'(load_err),   32'd0);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    clear_log();
    arst_n = 1'b1;
  endtask

  // Presents one byte until accepted; rnd randomly gaps rx_valid
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit acc;
    int tries;
    acc   = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      @(negedge clk);
      rx_data  = b;
      rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc      = rx_valid && rx_ready;
      @(posedge clk);
      tries++;
    end
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
    last_acc = ncyc;
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit rnd);
    foreach (s[k]) send_byte(s[k], rnd);
  endtask

  task automatic idle_valid(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 8'hFF;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic check_prog_writes(input string tag);
    check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check({tag, "_addr0"}, 32'(wr_addr[0]), 32'h0);
      check({tag, "_data0"}, wr_data[0],      32'h00100513);
      check({tag, "_addr1"}, 32'(wr_addr[1]), 32'h4);
      check({tag, "_data1"}, wr_data[1],      32'h00200593);
    end
  endtask

  initial begin
    logic [7:0] s[$];
    logic [31:0] w;
    arst_n   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    arst_n = 1'b1;

    // Back-to-back two-word program
    send_stream(prog, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    check("fin_wr_en", 32'(imem_wr_en), 32'd1);
    check("fin_done",  32'(load_done),  32'd0);
    check("fin_crst",  32'(core_rst_n), 32'd0);
    @(negedge clk);
    check("b2b_done",  32'(load_done),  32'd1);
    check("b2b_crst",  32'(core_rst_n), 32'd1);
    check("b2b_ready", 32'(rx_ready),   32'd0);
    check("b2b_wr_en", 32'(imem_wr_en), 32'd0);
    check("hold_addr", 32'(imem_addr),  32'h4);
    check("hold_data", imem_wdata,      32'h00200593);
    check_prog_writes("b2b");
    if (wr_cyc.size() == 2) begin
      check("b2b_gap",     32'(wr_cyc[1] - wr_cyc[0]), 32'd4);
      check("b2b_latency", 32'(wr_cyc[1]),             32'(last_acc + 1));
    end
    idle_valid(5);
    check("done_ignore_nwr", 32'(wr_addr.size()), 32'd2);
    check("done_sticky",     32'(load_done),      32'd1);

    // Same program with gapped rx_valid
    do_reset();
    send_stream(prog, 1'b1);
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check_prog_writes("rnd");
    check("rnd_done", 32'(load_done), 32'd1);

    // Empty image
    do_reset();
    s = '{8'h00, 8'h00};
    send_stream(s, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    check("empty_done",  32'(load_done),  32'd1);
    check("empty_crst",  32'(core_rst_n), 32'd1);
    check("empty_ready", 32'(rx_ready),   32'd0);
    idle_valid(4);
    check("empty_nwr",   32'(wr_addr.size()), 32'd0);

    // Oversize header: 257 words
    do_reset();
    s = '{8'h01, 8'h01};
    send_stream(s, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    check("err_flag",  32'(load_err),   32'd1);
    check("err_crst",  32'(core_rst_n), 32'd0);
    check("err_done",  32'(load_done),  32'd0);
    check("err_ready", 32'(rx_ready),   32'd0);
    idle_valid(8);
    check("err_nwr",   32'(wr_addr.size()), 32'd0);
    check("err_sticky", 32'(load_err),  32'd1);

    // Full image of DEPTH words
    do_reset();
    s = '{8'h00, 8'h01};
    for (int i = 0; i < 256; i++) begin
      w = wgen(i);
      s.push_back(w[7:0]);
      s.push_back(w[15:8]);
      s.push_back(w[23:16]);
      s.push_back(w[31:24]);
    end
    send_stream(s, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check("full_nwr", 32'(wr_addr.size()), 32'd256);
    if (wr_addr.size() == 256) begin
      for (int i = 0; i < 256; i++) begin
        check($sformatf("full_addr%0d", i), 32'(wr_addr[i]), 32'(4 * i));
        check($sformatf("full_data%0d", i), wr_data[i],      wgen(i));
      end
    end
    check("full_last_addr", 32'(imem_addr), 32'h3FC);
    check("full_done",      32'(load_done), 32'd1);
    check("full_err",       32'(load_err),  32'd0);

    // Reset in the middle of a load, then a clean reload
    do_reset();
    s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93};
    send_stream(s, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    arst_n   = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    clear_log();
    arst_n = 1'b1;
    send_stream(prog, 1'b0);
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check_prog_writes("reload");
    check("reload_done", 32'(load_done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the core's instruction memory. It receives a byte stream from an external link, such as a UART receiver, and assembles little-endian 32-bit words. It writes them sequentially into instruction memory starting at byte address 0, holding the core in reset until the image is complete. It sits beside `pak_rv_core` and drives the instruction memory write port and the core's `arst_n`.

## Interface
Parameters:
- `DATA_WIDTH`, 32: instruction word width; only 32 is supported.
- `IMEM_SZ_IN_KB`, 1: instruction memory size.
- `ADDR_WIDTH` (localparam), `$clog2(IMEM_SZ_IN_KB*1024)`: byte address width.
- `DEPTH` (localparam), `IMEM_SZ_IN_KB*256`: capacity in words.

Ports:
- `clk`  in  1: single clock; everything is sampled on the rising edge.
- `arst_n`  in  1: asynchronous, active-low reset.
- `rx_valid`  in  1: byte available on `rx_data`.
- `rx_data`  in  8: stream byte.
- `rx_ready`  out  1: loader accepts a byte this cycle.
- `imem_wr_en`  out  1: one-cycle instruction memory write strobe.
- `imem_addr`  out  ADDR_WIDTH: byte address, always word-aligned (bits [1:0] = 0).
- `imem_wdata`  out  DATA_WIDTH: word to write.
- `core_rst_n`  out  1: reset to the core; low until the load completes.
- `load_done`  out  1: image fully written.
- `load_err`  out  1: header length exceeded `DEPTH`.

## Operation
- **Stream format:** length L in words as 16-bit little-endian (low byte first), then L words, each as 4 bytes, least significant byte first.
- **Handshake:** a byte is accepted at a rising edge when `rx_valid && rx_ready`.
  - `rx_ready` = `arst_n` AND state ∈ {HDR_LO, HDR_HI, DATA}.
  - `rx_ready` is combinational from the state register and `arst_n`; it never depends on `rx_valid`.
- **States** (reset state HDR_LO):
  - HDR_LO: on accept, latch L[7:0] and go to HDR_HI.
  - HDR_HI: on accept, latch L[15:8], then:
    - L == 0 → DONE;
    - L > DEPTH → ERR;
    - otherwise → DATA.
  - DATA: bytes shift into a 32-bit assembly register at lane `byte_cnt` (2-bit counter, wraps 3→0).
    - On the 4th byte: register a write of the assembled word {b3,b2,b1,b0} at address 4·`word_cnt`.
    - `word_cnt` then increments.
    - If `word_cnt` == L−1 at that edge → FIN; otherwise stay in DATA.
  - FIN: one cycle; the final write strobe is active. Go to DONE.
  - DONE: terminal. `rx_ready` = 0, `load_done` = 1, `core_rst_n` = 1.
  - ERR: terminal. `rx_ready` = 0, `load_err` = 1, `core_rst_n` stays 0.
  - Only `arst_n` exits DONE or ERR.
- **Widths:** `word_cnt` is ADDR_WIDTH−2 bits. Because L ≤ DEPTH is enforced, the address never wraps. L is kept at 16 bits for the compares.
- **Reset mid-load:** asserting `arst_n` low at any point immediately returns to HDR_LO, clears the counters, and forces `core_rst_n` low. Memory contents already written are left as they are.

## Timing
- **Reset values:**
  - `rx_ready` 0, `imem_wr_en` 0, `imem_addr` 0, `imem_wdata` 0;
  - `core_rst_n` 0, `load_done` 0, `load_err` 0.
- **Write latency:** 4th byte of a word accepted at edge N → `imem_wr_en` high for exactly the cycle between edges N and N+1, with `imem_addr`/`imem_wdata` valid. Memory captures the word at edge N+1.
- **Write data hold:** `imem_addr`/`imem_wdata` hold their last value when the strobe is low.
- **Back-to-back bytes:** `rx_valid` held high gives one byte per cycle, and therefore one write every 4 cycles. No stalls are inserted; `rx_ready` stays 1 throughout DATA, including during a strobe cycle.
- **Completion:** final byte accepted at edge N → FIN during N..N+1 → `load_done`/`core_rst_n` high from edge N+1.
- **Empty image:** L = 0 → `load_done`/`core_rst_n` high the cycle after the HDR_HI accept.
- **Error:** `load_err` rises the cycle after the HDR_HI accept.
- **Ignored input:** `rx_valid` while `rx_ready` = 0 is ignored and the byte is dropped by protocol.

## Test plan
- Stream 02 00 13 05 10 00 93 05 20 00 with `rx_valid` always high → writes 0x00100513 @0x0 and 0x00200593 @0x4, four cycles apart. `load_done`/`core_rst_n` rise one cycle after the last byte.
- Same stream with `rx_valid` toggled randomly → identical writes and addresses. No byte is accepted while `rx_ready` = 0.
- Header 00 00 → `load_done` = 1 one cycle after the 2nd byte, zero write strobes, and `rx_ready` = 0 thereafter.
- Header with L = DEPTH+1 (e.g. 01 01 for 1 KB) → `load_err` = 1, `core_rst_n` stays 0, no writes, `rx_ready` = 0.
- Full image of L = DEPTH words → last write at address 4·(DEPTH−1), no address wrap, then DONE.
- `arst_n` pulsed low after 5 data bytes → all outputs return to reset values immediately. A fresh full stream then loads correctly from address 0.
